// File: rtl/rx_ds_pkg.sv
// Shared definitions for the DS-SE receive character path:
// sequencer states, control codes, error codes and the NULL hunt pattern.
package rx_ds_pkg;

  typedef enum logic [2:0] {
    ST_HUNT     = 3'd0,
    ST_RUN_HEAD = 3'd1,
    ST_RUN_CTRL = 3'd2,
    ST_RUN_DATA = 3'd3,
    ST_ERROR    = 3'd4
  } rx_state_e;

  localparam logic [1:0] CODE_FCT  = 2'b00;
  localparam logic [1:0] CODE_EOP1 = 2'b01;
  localparam logic [1:0] CODE_EOP2 = 2'b10;
  localparam logic [1:0] CODE_ESC  = 2'b11;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_ESC     = 3'd2;
  localparam logic [2:0] ERR_OVERRUN = 3'd3;
  localparam logic [2:0] ERR_DISC    = 3'd4;

  // Bit 7 is the oldest bit: ESC (P,1,1,1) then FCT (0,1,0,0); ESC parity is don't-care.
  localparam logic [7:0] NULL_PATTERN = 8'b0111_0100;
  localparam logic [7:0] NULL_MASK    = 8'b0111_1111;

endpackage

// File: rtl/rx_disc_timer.sv
// Disconnect watchdog: down-counter reloaded on every kick (or while idle);
// timeout flags the cycle whose edge completes DISC_CYCLES quiet cycles.
module rx_disc_timer #(
  parameter int DISC_CYCLES = 300,
  parameter int DISC_W      = 9
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic timeout
);

  localparam logic [DISC_W-1:0] LOAD = DISC_W'(DISC_CYCLES - 1);

  logic [DISC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || kick) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DISC_W'(1);
    end
  end

  assign timeout = run & ~kick & (cnt_q == '0);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_char_ctl.sv
// Receive character sequencer: NULL hunt, character parse, parity/escape
// checks and the valid/ready delivery register.
//   state    | meaning
//   HUNT     | sliding pair history, waiting for the first NULL
//   RUN_HEAD | expecting parity + flag pair
//   RUN_CTRL | expecting the 2-bit control code
//   RUN_DATA | collecting four data pairs
//   ERROR    | sticky until rxEnable drops or reset
module rx_char_ctl
  import rx_ds_pkg::*;
#(
  parameter int DISC_CYCLES = 300,
  parameter int DISC_W      = 9
) (
  input  logic       rxClk,
  input  logic       rxReset,
  input  logic       rxEnable,
  input  logic [1:0] dq,
  input  logic       dqValid,
  output logic [8:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  output logic       fctPulse,
  output logic       nullSeen,
  output logic       linkErr,
  output logic [2:0] errCode
);

  rx_state_e  state_q, state_d;
  logic [5:0] hist_q, hist_d;
  logic       acc_q, acc_d;
  logic       esc_q, esc_d;
  logic [1:0] pcnt_q, pcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [8:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       fct_q, fct_d;
  logic       null_q, null_d;
  logic       link_err_q, link_err_d;
  logic [2:0] err_q, err_d;

  logic [7:0] hist_shift;
  logic [7:0] byte_shift;
  logic       deliver;
  logic [8:0] char_new;
  logic       parity_err, esc_err, ovr_err;
  logic       timer_run, timeout;

  assign hist_shift = {hist_q, dq[0], dq[1]};
  assign byte_shift = {dq[1], dq[0], shift_q[7:2]};
  assign timer_run  = rxEnable & (state_q inside {ST_RUN_HEAD, ST_RUN_CTRL, ST_RUN_DATA});

  rx_disc_timer #(
    .DISC_CYCLES(DISC_CYCLES),
    .DISC_W     (DISC_W)
  ) u_disc_timer (
    .clk_sys(rxClk),
    .rst    (rxReset),
    .run    (timer_run),
    .kick   (dqValid),
    .timeout(timeout)
  );

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    acc_d      = acc_q;
    esc_d      = esc_q;
    pcnt_d     = pcnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fct_d      = 1'b0;
    null_d     = null_q;
    link_err_d = link_err_q;
    err_d      = err_q;
    deliver    = 1'b0;
    char_new   = '0;
    parity_err = 1'b0;
    esc_err    = 1'b0;
    ovr_err    = 1'b0;

    if (!rxEnable) begin
      state_d    = ST_HUNT;
      hist_d     = '0;
      acc_d      = 1'b0;
      esc_d      = 1'b0;
      valid_d    = 1'b0;
      null_d     = 1'b0;
      link_err_d = 1'b0;
      err_d      = ERR_NONE;
    end else begin
      if (valid_q && rxReady) valid_d = 1'b0;

      case (state_q)
        ST_HUNT: begin
          if (dqValid) begin
            hist_d = hist_shift[5:0];
            if ((hist_shift & NULL_MASK) == NULL_PATTERN) begin
              state_d = ST_RUN_HEAD;
              null_d  = 1'b1;
              acc_d   = ^CODE_FCT;
              esc_d   = 1'b0;
            end
          end
        end
        ST_RUN_HEAD: begin
          if (dqValid) begin
            parity_err = (acc_q ^ dq[0] ^ dq[1]) != 1'b1;
            acc_d      = 1'b0;
            pcnt_d     = 2'd0;
            state_d    = dq[1] ? ST_RUN_CTRL : ST_RUN_DATA;
          end
        end
        ST_RUN_CTRL: begin
          if (dqValid) begin
            acc_d   = acc_q ^ dq[0] ^ dq[1];
            state_d = ST_RUN_HEAD;
            if (esc_q) begin
              if (dq == CODE_FCT) esc_d = 1'b0;
              else                esc_err = 1'b1;
            end else begin
              case (dq)
                CODE_ESC:  esc_d = 1'b1;
                CODE_FCT:  fct_d = 1'b1;
                CODE_EOP1: begin deliver = 1'b1; char_new = 9'h100; end
                default:   begin deliver = 1'b1; char_new = 9'h101; end
              endcase
            end
          end
        end
        ST_RUN_DATA: begin
          if (dqValid) begin
            acc_d   = acc_q ^ dq[0] ^ dq[1];
            shift_d = byte_shift;
            pcnt_d  = pcnt_q + 2'd1;
            if (pcnt_q == 2'd3) begin
              state_d = ST_RUN_HEAD;
              if (esc_q) begin
                esc_err = 1'b1;
              end else begin
                deliver  = 1'b1;
                char_new = {1'b0, byte_shift};
              end
            end
          end
        end
        ST_ERROR: valid_d = 1'b0;
        default:  state_d = ST_HUNT;
      endcase

      // A pending character that is not being taken this cycle cannot be overwritten.
      if (deliver) begin
        if (valid_q && !rxReady) begin
          ovr_err = 1'b1;
        end else begin
          data_d  = char_new;
          valid_d = 1'b1;
        end
      end

      if (timeout || parity_err || esc_err || ovr_err) begin
        state_d    = ST_ERROR;
        link_err_d = 1'b1;
        valid_d    = 1'b0;
        fct_d      = 1'b0;
        if (timeout)         err_d = ERR_DISC;
        else if (parity_err) err_d = ERR_PARITY;
        else if (esc_err)    err_d = ERR_ESC;
        else                 err_d = ERR_OVERRUN;
      end
    end
  end

  always_ff @(posedge rxClk or posedge rxReset) begin
    if (rxReset) begin
      state_q    <= ST_HUNT;
      hist_q     <= '0;
      acc_q      <= 1'b0;
      esc_q      <= 1'b0;
      pcnt_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fct_q      <= 1'b0;
      null_q     <= 1'b0;
      link_err_q <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      acc_q      <= acc_d;
      esc_q      <= esc_d;
      pcnt_q     <= pcnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fct_q      <= fct_d;
      null_q     <= null_d;
      link_err_q <= link_err_d;
      err_q      <= err_d;
    end
  end

  assign rxData   = data_q;
  assign rxValid  = valid_q;
  assign fctPulse = fct_q;
  assign nullSeen = null_q;
  assign linkErr  = link_err_q;
  assign errCode  = err_q;

endmodule

// File: tb/tb_rx_char_ctl.sv
// Bench for rx_char_ctl: character-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rx_char_ctl;

  localparam int DISC = 300;

  logic       rxClk = 1'b0;
  logic       rxReset, rxEnable, dqValid, rxReady;
  logic [1:0] dq;
  logic [8:0] rxData;
  logic       rxValid, fctPulse, nullSeen, linkErr;
  logic [2:0] errCode;

  always #5 rxClk = ~rxClk;

  rx_char_ctl #(.DISC_CYCLES(DISC), .DISC_W(9)) dut (
    .rxClk   (rxClk),
    .rxReset (rxReset),
    .rxEnable(rxEnable),
    .dq      (dq),
    .dqValid (dqValid),
    .rxData  (rxData),
    .rxValid (rxValid),
    .rxReady (rxReady),
    .fctPulse(fctPulse),
    .nullSeen(nullSeen),
    .linkErr (linkErr),
    .errCode (errCode)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;
  bit tx_par   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works on whole characters collected from the bit stream.
  bit m_run, m_err, m_prev_par, m_esc, m_valid, m_fct, m_null;
  bit m_hist[$];
  bit m_cb[$];
  int m_idle, m_data, m_code;

  function automatic void m_reset();
    m_run = 0; m_err = 0; m_prev_par = 0; m_esc = 0; m_valid = 0; m_fct = 0;
    m_null = 0; m_hist.delete(); m_cb.delete(); m_idle = 0; m_data = 0; m_code = 0;
  endfunction

  function automatic void m_step(bit en, bit v, bit [1:0] d, bit rdy);
    bit old_valid, have, e_disc, e_par, e_esc, e_ovr, par;
    int dc, code;
    m_fct = 0;
    if (!en) begin
      m_run = 0; m_err = 0; m_esc = 0; m_valid = 0; m_null = 0; m_code = 0;
      m_idle = 0; m_hist.delete(); m_cb.delete();
      return;
    end
    if (m_err) begin
      m_valid = 0;
      return;
    end
    old_valid = m_valid;
    if (m_valid && rdy) m_valid = 0;
    have = 0; e_disc = 0; e_par = 0; e_esc = 0; e_ovr = 0; dc = 0;
    if (!m_run) begin
      if (v) begin
        m_hist.push_back(d[0]);
        m_hist.push_back(d[1]);
        while (m_hist.size() > 8) void'(m_hist.pop_front());
        if (m_hist.size() == 8 && m_hist[1] && m_hist[2] && m_hist[3] && !m_hist[4] &&
            m_hist[5] && !m_hist[6] && !m_hist[7]) begin
          m_run = 1; m_null = 1; m_prev_par = 0; m_esc = 0; m_idle = 0; m_cb.delete();
        end
      end
    end else if (v) begin
      m_idle = 0;
      m_cb.push_back(d[0]);
      m_cb.push_back(d[1]);
      if (m_cb.size() == 2 && (m_prev_par ^ m_cb[0] ^ m_cb[1]) != 1'b1) e_par = 1;
      if (m_cb.size() == 4 && m_cb[1]) begin
        code = int'(m_cb[2]) + 2 * int'(m_cb[3]);
        m_prev_par = m_cb[2] ^ m_cb[3];
        m_cb.delete();
        if (m_esc) begin
          if (code == 0) m_esc = 0;
          else e_esc = 1;
        end else begin
          case (code)
            0: m_fct = 1;
            1: begin have = 1; dc = 'h100; end
            2: begin have = 1; dc = 'h101; end
            default: m_esc = 1;
          endcase
        end
      end
      if (m_cb.size() == 10 && !m_cb[1]) begin
        par = 0;
        for (int i = 0; i < 8; i++) begin
          dc = dc | (int'(m_cb[2+i]) << i);
          par = par ^ m_cb[2+i];
        end
        m_prev_par = par;
        m_cb.delete();
        if (m_esc) e_esc = 1;
        else have = 1;
      end
    end else begin
      m_idle++;
      if (m_idle >= DISC) e_disc = 1;
    end
    if (have) begin
      if (old_valid && !rdy) e_ovr = 1;
      else begin m_data = dc; m_valid = 1; end
    end
    if (e_disc || e_par || e_esc || e_ovr) begin
      m_err = 1; m_valid = 0; m_fct = 0;
      m_code = e_disc ? 4 : e_par ? 1 : e_esc ? 2 : 3;
    end
  endfunction

  always @(posedge rxClk or posedge rxReset) begin
    if (rxReset) m_reset();
    else m_step(rxEnable, dqValid, dq, rxReady);
  end

  always @(negedge rxClk) begin
    if (cmp_en) begin
      chk("model rxData", rxData, m_data);
      chk("model rxValid", rxValid, m_valid);
      chk("model fctPulse", fctPulse, m_fct);
      chk("model nullSeen", nullSeen, m_null);
      chk("model linkErr", linkErr, m_err);
      chk("model errCode", errCode, m_code);
    end
  end

  // Stimulus tasks start and end on a falling edge.
  task automatic pair(input logic [1:0] p);
    dq = p; dqValid = 1'b1;
    @(negedge rxClk);
    dqValid = 1'b0; dq = 2'b00;
  endtask

  task automatic hunt_null();
    pair(2'b11); pair(2'b11); pair(2'b10); pair(2'b00);
    tx_par = 0;
  endtask

  task automatic ctrl_head();
    pair({1'b1, tx_par});
  endtask

  task automatic ctrl_code(input logic [1:0] c);
    pair(c);
    tx_par = c[0] ^ c[1];
  endtask

  task automatic send_ctrl(input logic [1:0] c);
    ctrl_head();
    ctrl_code(c);
  endtask

  task automatic send_data(input logic [7:0] b, input bit bad);
    pair({1'b0, ~tx_par ^ bad});
    for (int k = 0; k < 4; k++) pair(b[2*k +: 2]);
    tx_par = ^b;
  endtask

  task automatic send_null();
    send_ctrl(2'b11);
    send_ctrl(2'b00);
  endtask

  task automatic disable_cycle();
    rxEnable = 1'b0;
    @(negedge rxClk);
    rxEnable = 1'b1;
  endtask

  initial begin
    rxReset = 1'b1; rxEnable = 1'b0; dqValid = 1'b0; dq = 2'b00; rxReady = 1'b1;
    repeat (3) @(negedge rxClk);
    rxReset = 1'b0;
    cmp_en  = 1;
    chk("reset rxData", rxData, 0);
    chk("reset rxValid", rxValid, 0);
    chk("reset nullSeen", nullSeen, 0);
    chk("reset linkErr", linkErr, 0);
    chk("reset errCode", errCode, 0);
    chk("reset fctPulse", fctPulse, 0);

    // First NULL acquisition, then data and control characters.
    rxEnable = 1'b1;
    hunt_null();
    chk("null nullSeen", nullSeen, 1);
    chk("null rxValid", rxValid, 0);
    chk("null fctPulse", fctPulse, 0);
    send_data(8'hA5, 0);
    chk("a5 rxValid", rxValid, 1);
    chk("a5 rxData", rxData, 'h0A5);
    chk("a5 linkErr", linkErr, 0);
    send_ctrl(2'b00);
    chk("fct pulse", fctPulse, 1);
    rxReady = 1'b0;
    send_data(8'h5A, 0);
    chk("5a rxData", rxData, 'h05A);
    ctrl_head();
    chk("5a held", rxValid, 1);
    rxReady = 1'b1;
    ctrl_code(2'b10);
    chk("eop2 rxData", rxData, 'h101);
    chk("eop2 rxValid", rxValid, 1);
    send_null();
    chk("null2 rxValid", rxValid, 0);
    chk("null2 fctPulse", fctPulse, 0);

    // Parity error, sticky until rxEnable drops.
    send_data(8'h3C, 1);
    chk("parity linkErr", linkErr, 1);
    chk("parity errCode", errCode, 1);
    repeat (5) @(negedge rxClk);
    chk("parity held", errCode, 1);
    disable_cycle();
    chk("parity cleared errCode", errCode, 0);
    chk("parity cleared linkErr", linkErr, 0);
    chk("parity cleared nullSeen", nullSeen, 0);
    pair(2'b01); pair(2'b10); pair(2'b11);

    // Escape followed by EOP_1.
    hunt_null();
    chk("esc nullSeen", nullSeen, 1);
    send_ctrl(2'b11);
    send_ctrl(2'b01);
    chk("esc errCode", errCode, 2);
    chk("esc linkErr", linkErr, 1);
    disable_cycle();

    // Overrun: second character while the first is still unaccepted.
    hunt_null();
    rxReady = 1'b0;
    send_data(8'h11, 0);
    chk("ovr first rxData", rxData, 'h011);
    chk("ovr first rxValid", rxValid, 1);
    send_data(8'h22, 0);
    chk("ovr errCode", errCode, 3);
    chk("ovr rxData kept", rxData, 'h011);
    chk("ovr rxValid", rxValid, 0);
    rxReady = 1'b1;
    disable_cycle();

    // Disconnect exactly DISC cycles after the last dqValid.
    hunt_null();
    repeat (DISC - 1) @(negedge rxClk);
    chk("disc early linkErr", linkErr, 0);
    @(negedge rxClk);
    chk("disc linkErr", linkErr, 1);
    chk("disc errCode", errCode, 4);
    disable_cycle();

    // Asynchronous reset in the middle of a data character.
    hunt_null();
    pair({1'b0, ~tx_par});
    pair(2'b01);
    pair(2'b10);
    #2 rxReset = 1'b1;
    #1;
    chk("async nullSeen", nullSeen, 0);
    chk("async rxData", rxData, 0);
    chk("async rxValid", rxValid, 0);
    chk("async linkErr", linkErr, 0);
    @(negedge rxClk);
    rxReset = 1'b0;
    hunt_null();
    chk("reacquire nullSeen", nullSeen, 1);
    send_data(8'hC3, 0);
    chk("reacquire rxData", rxData, 'h0C3);
    repeat (3) @(negedge rxClk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
